// File: rtl/grf_wb_queue_if.sv
// Handshake and register-file write-port bundle for the write-back commit queue.
// The master modport belongs to the producer/arbiter side; the slave modport belongs to the queue.
interface grf_wb_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_addr;
  logic [31:0] in_data;

  logic        port_grant;
  logic        grf_we;
  logic [31:0] grf_pc;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd3;

  modport master (
    output in_valid, in_pc, in_addr, in_data, port_grant,
    input  in_ready, grf_we, grf_pc, grf_a3, grf_wd3
  );

  modport slave (
    input  in_valid, in_pc, in_addr, in_data, port_grant,
    output in_ready, grf_we, grf_pc, grf_a3, grf_wd3
  );
endinterface

// File: rtl/grf_wb_queue.sv
// In-order write-back commit queue feeding the register file's single write port.
// Queued entries can also be read back through two bypass lookup ports.
module grf_wb_queue #(
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  grf_wb_queue_if.slave            bus,
  input  logic [4:0]               q_a1_i,
  input  logic [4:0]               q_a2_i,
  output logic                     q_hit1_o,
  output logic                     q_hit2_o,
  output logic [31:0]              q_data1_o,
  output logic [31:0]              q_data2_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     empty_o
);
  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   pc_q   [Depth];
  logic [4:0]    addr_q [Depth];
  logic [31:0]   data_q [Depth];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic full, empty, accept, store, commit;

  assign full   = (count_q == CW'(Depth));
  assign empty  = (count_q == '0);
  assign accept = bus.in_valid && !full;
  // Writes to $0 complete the handshake but are never stored.
  assign store  = accept && (bus.in_addr != 5'd0);
  assign commit = !empty && bus.port_grant;

  assign bus.in_ready = !full;
  assign bus.grf_we   = commit;
  assign bus.grf_pc   = empty ? 32'd0 : pc_q[head_q];
  assign bus.grf_a3   = empty ? 5'd0  : addr_q[head_q];
  assign bus.grf_wd3  = empty ? 32'd0 : data_q[head_q];
  assign count_o      = count_q;
  assign empty_o      = empty;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (store)  tail_d = tail_q + AW'(1);
    if (commit) head_d = head_q + AW'(1);
    if (store && !commit)      count_d = count_q + CW'(1);
    else if (!store && commit) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (store) begin
      pc_q[tail_q]   <= bus.in_pc;
      addr_q[tail_q] <= bus.in_addr;
      data_q[tail_q] <= bus.in_data;
    end
  end

  // Walk from oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    q_hit1_o  = 1'b0;
    q_hit2_o  = 1'b0;
    q_data1_o = 32'd0;
    q_data2_o = 32'd0;
    for (int unsigned k = 0; k < Depth; k++) begin
      if (CW'(k) < count_q) begin
        if (q_a1_i != 5'd0 && addr_q[head_q + AW'(k)] == q_a1_i) begin
          q_hit1_o  = 1'b1;
          q_data1_o = data_q[head_q + AW'(k)];
        end
        if (q_a2_i != 5'd0 && addr_q[head_q + AW'(k)] == q_a2_i) begin
          q_hit2_o  = 1'b1;
          q_data2_o = data_q[head_q + AW'(k)];
        end
      end
    end
  end
endmodule
